// File: rtl/shift_add_multiplier_4bit.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_multiplier_4bit
// Brief    : Sequential unsigned shift-and-add multiplier with start/busy/done
//            handshake, built on an add/subtract stage held in add mode.
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_multiplier_4bit #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_CALC = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

   localparam logic          c_K          = 1'b0;
   localparam logic [CW-1:0] c_COUNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0] c_COUNT_LAST = CW'(1);

   logic [1:0]       r_state;
   logic [1:0]       w_next_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_m;
   logic [CW-1:0]    r_count;

   logic [WIDTH-1:0] w_b;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_add;
   logic [WIDTH-1:0] w_a_next;
   logic [WIDTH-1:0] w_q_next;
   logic             w_last;

   // Add/subtract stage with K tied low; w_sum[WIDTH] is the carry-out C.
   assign w_b      = r_m ^ {WIDTH{c_K}};
   assign w_sum    = {1'b0, r_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, c_K};
   assign w_add    = r_q[0] ? w_sum : {1'b0, r_a};
   assign w_a_next = w_add[WIDTH:1];
   assign w_q_next = {w_add[0], r_q[WIDTH-1:1]};
   assign w_last   = (r_count == c_COUNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE:  if (start) w_next_state = c_CALC;
         c_CALC:  if (w_last) w_next_state = c_DONE;
         c_DONE:  w_next_state = c_IDLE;
         default: w_next_state = c_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == c_CALC);
      done = (r_state == c_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_q     <= '0;
         r_m     <= '0;
         r_count <= '0;
         product <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  r_m     <= multiplicand;
                  r_q     <= multiplier;
                  r_a     <= '0;
                  r_count <= c_COUNT_INIT;
               end
            end
            c_CALC: begin
               r_a     <= w_a_next;
               r_q     <= w_q_next;
               r_count <= r_count - 1'b1;
               if (w_last) begin
                  product <= {w_a_next, w_q_next};
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier_4bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_add_multiplier_4bit
// Brief    : Scoreboard bench with randomized operands against an M*Q model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_add_multiplier_4bit;

   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [W-1:0]   multiplicand = '0;
   logic [W-1:0]   multiplier = '0;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;

   int n_cmp = 0;
   int n_err = 0;

   int unsigned exp_q[$];
   int          rem = 0;
   logic        rst_seen = 1'b0;
   int unsigned hold = 0;

   shift_add_multiplier_4bit #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: an accepted start yields M*Q; the block is unavailable for
   // WIDTH busy cycles plus one done cycle afterwards.
   always @(posedge clk) begin
      rst_seen <= rst;
      if (rst) begin
         rem <= 0;
         exp_q.delete();
      end else if (rem == 0) begin
         if (start) begin
            exp_q.push_back(int'(multiplicand) * int'(multiplier));
            rem <= W + 1;
         end
      end else begin
         rem <= rem - 1;
      end
   end

   always @(negedge clk) begin
      if (rst_seen) hold = 0;
      check("busy", {31'd0, busy}, {31'd0, (rem >= 2)});
      check("done", {31'd0, done}, {31'd0, (rem == 1)});
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("done_without_request", 32'd1, 32'd0);
         end else begin
            hold = exp_q.pop_front();
            check("product", {24'd0, product}, hold);
         end
      end else begin
         check("product_hold", {24'd0, product}, hold);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One accepted operation; the gap cycles carry random, ignored start pulses.
   task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input bit noise);
      start        = 1'b1;
      multiplicand = m;
      multiplier   = q;
      tick();
      for (int i = 0; i < W + 1; i++) begin
         start        = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         multiplicand = W'($urandom);
         multiplier   = W'($urandom);
         tick();
      end
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();

      run_op(4'd15, 4'd15, 1'b0);
      run_op(4'd0,  4'd9,  1'b0);
      run_op(4'd9,  4'd0,  1'b0);
      run_op(4'd13, 4'd11, 1'b1);

      // Second request two edges into an operation must be ignored.
      start = 1'b1; multiplicand = 4'd3; multiplier = 4'd5;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1; multiplicand = 4'd15; multiplier = 4'd15;
      tick();
      start = 1'b0;
      repeat (W) tick();

      for (int m = 0; m < 16; m++) begin
         for (int q = 0; q < 16; q++) begin
            run_op(W'(m), W'(q), 1'b1);
         end
      end

      // Abort mid-operation, then a clean run.
      start = 1'b1; multiplicand = 4'd12; multiplier = 4'd10;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      run_op(4'd2, 4'd7, 1'b0);

      // Start held high: back-to-back operations.
      start = 1'b1; multiplicand = 4'd6; multiplier = 4'd7;
      repeat (3 * (W + 2)) tick();
      start = 1'b0;
      repeat (W + 2) tick();

      for (int i = 0; i < 40; i++) begin
         run_op(W'($urandom), W'($urandom), 1'b1);
      end

      repeat (W + 3) tick();
      check("scoreboard_drained", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/shift_add_multiplier_4bit.md
Name: shift_add_multiplier_4bit

Overview:
- Sequential unsigned multiplier built around the team's 4-bit add/subtract stage.
- The adder is driven in add mode only (K=0), once per cycle, for WIDTH cycles.
- Produces a 2*WIDTH-bit product with a start/busy/done handshake.
- Sits directly downstream of the 4-bit adder and consumes its sum and carry every iteration.

Parameters:
- WIDTH, 4, operand width in bits. The adder datapath is WIDTH bits wide and the product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- multiplicand  input  WIDTH  operand M, unsigned; sampled on the accepted start edge.
- multiplier  input  WIDTH  operand Q, unsigned; sampled on the accepted start edge.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse; product is valid.
- product  output  2*WIDTH  registered result; holds until the next completion or reset.

Behaviour:
- Clock and reset: one clock domain (clk). rst is synchronous, active-high, and takes priority over everything.
- Reset values: state=IDLE, busy=0, done=0, product=0, all internal registers (A, Q, M, C, count) = 0.
- FSM has three states: IDLE, CALC, DONE.
- IDLE, start=1 at edge N:
  - M<=multiplicand, Q<=multiplier, A<=0, C<=0, count<=WIDTH.
  - Next state is CALC.
- IDLE, start=0: stay in IDLE; outputs hold.
- CALC, each edge N+1..N+WIDTH:
  - If Q[0]=1: {C,A} <= A+M (WIDTH-bit add plus carry-out). Otherwise {C,A} <= {0,A}.
  - Then shift right one bit: {C,A,Q} <= {0,C,A,Q[WIDTH-1:1]} combined with the add result. Net effect: {A,Q} <= ({C, A+M or A, Q}) >> 1.
  - count decrements by 1.
- Completion, edge where count reaches 0 (edge N+WIDTH):
  - The final step is performed.
  - product <= final {A,Q}, state <= DONE, done <= 1.
- DONE: lasts exactly one cycle.
  - At edge N+WIDTH+1: state <= IDLE, done <= 0.
  - start during DONE is ignored.
- Latency and throughput:
  - done is high in the cycle after edge N+WIDTH, i.e. WIDTH edges after the start edge.
  - Next accepted start is at edge N+WIDTH+2 at the earliest.
- busy is 1 exactly in CALC: WIDTH cycles per operation.
- start while busy or done is ignored. Operand input changes after the start edge have no effect.
- Width rule: product is 2*WIDTH bits, so it cannot overflow. Carry-out is kept in C and shifted into A[WIDTH-1] each step; no bit is lost.
- product changes only at completion or reset. It holds its last value through IDLE and the whole next operation.
- Reset in mid-operation (any state): abort immediately. Return to reset values; product is cleared to 0 and no done pulse is issued.
- start held high continuously: a new operation is accepted at each IDLE cycle. Back-to-back period is WIDTH+2 cycles.

Test Plan:
- Reset, then M=15, Q=15, 1-cycle start at edge 0 -> busy high for cycles 1-4; done pulse after edge 4; product=225 (8'hE1). The carry path is exercised every step.
- M=0, Q=9 -> product=0 with done after 4 cycles. Then M=9, Q=0 -> product=0. Previous product must hold until each completion.
- Exhaustive sweep M,Q in 0..15, each started after the previous done -> product=M*Q for all 256 pairs. Example: 13*11=143 (8'h8F).
- M=3, Q=5 started; at edge 2 assert start with M=15, Q=15 (ignored); operand pins change -> product=15, exactly one done pulse.
- M=12, Q=10 started; rst=1 at edge 2 for one cycle -> busy=0, done=0, product=0 on the next cycle; no done pulse; a following 2*7 run yields 14.
- start held high with M=6, Q=7 -> done pulses every 6 cycles, product=42 each time.
